// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the 4-digit multiplexed 7-segment scan controller.
//   - state_t     : scan FSM encoding (dead-time blank / digit shown)
//   - disp_cfg_t  : one complete display image (digit nibbles, enables, dots)
//   - SEG_OFF     : full 12-bit bus with every anode and cathode inactive
//   - AN_OFF      : all four anodes inactive
//   - HEX_TABLE   : 16-entry {a,b,c,d,e,f,g} active-low cathode patterns
//   - anode_sel() : active-low one-cold anode pattern for a digit index
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Everything the display needs to render one frame.
  typedef struct packed {
    logic [15:0] value;   // [15:12] digit3 (leftmost) .. [3:0] digit0
    logic [3:0]  dig_en;  // 1 = digit lit in its slot
    logic [3:0]  dp_en;   // 1 = decimal point lit
  } disp_cfg_t;

  localparam disp_cfg_t   CFG_CLEAR = '0;
  localparam logic [11:0] SEG_OFF   = 12'hFFF;
  localparam logic [3:0]  AN_OFF    = 4'hF;

  // Cathode patterns, active-low, bit order {a,b,c,d,e,f,g}.
  // Entry n is selected by HEX_TABLE[n]; the list is written F down to 0.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Active-low anode pattern with only digit idx driven.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return AN_OFF & ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
//   Purely combinational hex digit to 7-segment decoder.
//   Ports:
//     nibble  in  4  hex digit 0..F
//     seg_n   out 7  {a,b,c,d,e,f,g}, active-low
// ---------------------------------------------------------------------------
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexes one shared 12-bit display bus (4 anodes + 8 cathodes)
//   across four hex digits. Each digit owns a slot of CLK_DIV cycles: the
//   first BLANK_CYC cycles drive everything off (dead time against ghosting),
//   the rest show the digit. Slots run digit3, digit2, digit1, digit0, then
//   repeat. New display images are captured into a staging register and only
//   copied into the shadow register that drives the display at the frame
//   boundary, so a frame never mixes old and new digits.
//
//   Parameters:
//     CLK_DIV    cycles per digit slot (blank + show), must be >= BLANK_CYC+1
//     BLANK_CYC  all-off cycles at the start of each slot, 0 disables blanking
//
//   Ports:
//     clk          in   1   system clock, rising edge
//     reset_in     in   1   synchronous, active-low reset
//     load         in   1   strobe: capture value/dig_en/dp_en into staging
//     value        in   16  four hex nibbles, [15:12] = digit3 (leftmost)
//     dig_en       in   4   per-digit enable
//     dp_en        in   4   per-digit decimal point enable
//     segment      out  12  [11:8] an[3:0] active-low, [7:0] {a..g,dp} active-low
//     frame_done   out  1   one-cycle pulse following every frame boundary
//     upd_pending  out  1   staging holds an image not yet on the display
// ---------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 50
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dig_en,
  input  logic [3:0]  dp_en,
  output logic [11:0] segment,
  output logic        frame_done,
  output logic        upd_pending
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  // Every slot starts in this state; with no dead time the blank phase is
  // skipped entirely and a slot is SHOW from its first cycle.
  localparam state_t ST_SLOT_START = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  state_t           state_q;
  state_t           state_d;

  logic             slot_end;
  logic             frame_end;

  disp_cfg_t        cfg_in;
  disp_cfg_t        staging_q;
  disp_cfg_t        shadow_q;
  logic             pend_q;

  logic [3:0]       cur_nibble;
  logic [6:0]       cur_cath;
  logic [11:0]      seg_d;
  logic [11:0]      seg_q;
  logic             fd_q;

  assign cfg_in = '{value: value, dig_en: dig_en, dp_en: dp_en};

  // Last cycle of a slot, and the last cycle of the digit0 slot which closes
  // the frame. The FSM is always in SHOW on a slot's last cycle because the
  // blank phase is strictly shorter than the slot.
  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == 2'd0) && (state_q == ST_SHOW);

  // -------------------------------------------------------------------------
  // Slot counter: 0..CLK_DIV-1, wraps only at slot end
  // -------------------------------------------------------------------------
  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      cnt_q <= '0;
    end else if (slot_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Digit index: 3 -> 2 -> 1 -> 0 -> 3, advancing at each slot end.
  // The 2-bit decrement wraps from 0 to 3 by itself.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      idx_q <= 2'd3;
    end else if (slot_end) begin
      idx_q <= idx_q - 2'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state_q <= ST_SLOT_START;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM: next state
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default at
  // the top; a path that leaves it unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_SHOW;
      end
    end else begin
      if (slot_end) begin
        state_d = ST_SLOT_START;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM: output decode (registered below)
  // -------------------------------------------------------------------------
  assign cur_nibble = shadow_q.value[{idx_q, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (cur_nibble),
    .seg_n  (cur_cath)
  );

  // A disabled digit keeps its anode off as well, so its slot is all-off.
  always_comb begin
    seg_d = SEG_OFF;
    if ((state_q == ST_SHOW) && shadow_q.dig_en[idx_q]) begin
      seg_d = {anode_sel(idx_q), cur_cath, ~shadow_q.dp_en[idx_q]};
    end
  end

  // -------------------------------------------------------------------------
  // Staging / shadow images
  //   load outside the boundary : staging <= inputs, pending set
  //   boundary, no load         : shadow  <= staging if pending, pending clear
  //   boundary with load        : shadow  <= inputs directly, pending clear
  // -------------------------------------------------------------------------
  // NOTE: the image registers are reset along with the control state so the
  // display comes up dark rather than showing whatever the flops powered up to.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      staging_q <= CFG_CLEAR;
      shadow_q  <= CFG_CLEAR;
      pend_q    <= 1'b0;
    end else begin
      if (load) begin
        staging_q <= cfg_in;
      end
      if (frame_end) begin
        if (load) begin
          shadow_q <= cfg_in;
        end else if (pend_q) begin
          shadow_q <= staging_q;
        end
        pend_q <= 1'b0;
      end else if (load) begin
        pend_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output registers: the pins see the previous cycle's decode, which keeps
  // the board pins glitch-free.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      seg_q <= SEG_OFF;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      fd_q  <= frame_end;
    end
  end

  assign segment     = seg_q;
  assign frame_done  = fd_q;
  assign upd_pending = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Scoreboard bench. Stimulus pushes the hand-computed show value of each
//   slot of every frame it expects into a queue; a monitor collects the
//   segment bus each cycle and, whenever frame_done pulses, pops one frame
//   and compares the 32 (or 16) cycles that made up that frame.
//   u_dut  : CLK_DIV=8, BLANK_CYC=2
//   u_dut6 : CLK_DIV=4, BLANK_CYC=0
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  typedef logic [3:0][11:0] frame_t;  // [0] = digit3 slot .. [3] = digit0 slot

  typedef struct {
    int          ld_a;    // load offset within frame, -1 = none
    logic [23:0] cfg_a;   // {value, dig_en, dp_en}
    int          ld_b;
    logic [23:0] cfg_b;
    frame_t      exp;
  } vec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        reset_in, load;
  logic [15:0] value;
  logic [3:0]  dig_en, dp_en;
  logic [11:0] segment;
  logic        frame_done, upd_pending;

  // No-blank instance
  logic        rst6, load6;
  logic [15:0] value6;
  logic [3:0]  dig_en6, dp_en6;
  logic [11:0] segment6;
  logic        frame_done6, upd_pending6;

  seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) u_dut (
    .clk         (clk),
    .reset_in    (reset_in),
    .load        (load),
    .value       (value),
    .dig_en      (dig_en),
    .dp_en       (dp_en),
    .segment     (segment),
    .frame_done  (frame_done),
    .upd_pending (upd_pending)
  );

  seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(0)) u_dut6 (
    .clk         (clk),
    .reset_in    (rst6),
    .load        (load6),
    .value       (value6),
    .dig_en      (dig_en6),
    .dp_en       (dp_en6),
    .segment     (segment6),
    .frame_done  (frame_done6),
    .upd_pending (upd_pending6)
  );

  int     checks = 0;
  int     errors = 0;
  frame_t exp_q[$];
  frame_t exp6_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [11:0] s3, input logic [11:0] s2,
                                input logic [11:0] s1, input logic [11:0] s0);
    frame_t f;
    f[0] = s3;
    f[1] = s2;
    f[2] = s1;
    f[3] = s0;
    return f;
  endfunction

  // -------------------------------------------------------------------------
  // Monitor, main instance. Sample k of a frame window reflects slot counter
  // state k: slot k/8, phase k%8, phases 0..1 blank.
  // -------------------------------------------------------------------------
  initial begin : mon_main
    logic [11:0] win [32];
    frame_t      f;
    int          since_fd;
    bit          seen_fd;
    int          frame_no;
    logic [11:0] e;
    since_fd = 0;
    seen_fd  = 1'b0;
    frame_no = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 31; i++) win[i] = win[i+1];
      win[31] = segment;
      if (reset_in !== 1'b1) seen_fd = 1'b0;
      since_fd++;
      if (frame_done === 1'b1) begin
        if (seen_fd) check($sformatf("fd_period_f%0d", frame_no), since_fd, 32);
        seen_fd  = 1'b1;
        since_fd = 0;
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_frame_%0d", frame_no), 32'd1, 32'd0);
        end else begin
          f = exp_q.pop_front();
          for (int i = 0; i < 32; i++) begin
            e = ((i % 8) < 2) ? 12'hFFF : f[i/8];
            check($sformatf("seg_f%0d_k%0d", frame_no, i), win[i], e);
          end
        end
        frame_no++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor, no-blank instance: 16-cycle frames, 4 cycles per slot, no blank.
  // -------------------------------------------------------------------------
  initial begin : mon_six
    logic [11:0] win [16];
    frame_t      f;
    int          frame_no;
    frame_no = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 15; i++) win[i] = win[i+1];
      win[15] = segment6;
      if (frame_done6 === 1'b1) begin
        if (exp6_q.size() == 0) begin
          check($sformatf("unexpected_frame6_%0d", frame_no), 32'd1, 32'd0);
        end else begin
          f = exp6_q.pop_front();
          for (int i = 0; i < 16; i++)
            check($sformatf("seg6_f%0d_k%0d", frame_no, i), win[i], f[i/4]);
        end
        frame_no++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // One 32-cycle frame of stimulus, entered on the negedge of slot-counter
  // cycle 0. Also checks upd_pending every cycle: it is 1 exactly on the
  // cycles after a non-boundary load, until the frame ends.
  // -------------------------------------------------------------------------
  task automatic run_frame(input int n, input vec_t v);
    bit exp_p;
    exp_q.push_back(v.exp);
    for (int k = 0; k < 32; k++) begin
      exp_p = ((v.ld_a >= 0) && (v.ld_a < 31) && (k > v.ld_a)) ||
              ((v.ld_b >= 0) && (v.ld_b < 31) && (k > v.ld_b));
      check($sformatf("pend_f%0d_k%0d", n, k), {31'd0, upd_pending}, {31'd0, exp_p});
      load = 1'b0;
      if (k == v.ld_a) begin
        load = 1'b1;
        {value, dig_en, dp_en} = v.cfg_a;
      end
      if (k == v.ld_b) begin
        load = 1'b1;
        {value, dig_en, dp_en} = v.cfg_b;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin : stim
    // F0: dark; two loads, the later one (0123) must win
    vecs[0] = '{4,  {16'h1111, 4'hF, 4'h0}, 10, {16'h0123, 4'hF, 4'h0},
                mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF)};
    // F1: shows 0123; 4567 loaded during digit2 slot must not tear it
    vecs[1] = '{12, {16'h4567, 4'hF, 4'h0}, -1, 24'h0,
                mk(12'h703, 12'hB9F, 12'hD25, 12'hE0D)};
    // F2: shows 4567; load partial enables with dot on digit0
    vecs[2] = '{5,  {16'h89AB, 4'h5, 4'h1}, -1, 24'h0,
                mk(12'h799, 12'hB49, 12'hD41, 12'hE1F)};
    // F3: digit3/digit1 dark; load lands on the boundary cycle (bypass)
    vecs[3] = '{31, {16'hCDEF, 4'hF, 4'hA}, -1, 24'h0,
                mk(12'hFFF, 12'hB09, 12'hFFF, 12'hEC0)};
    // F4: bypassed image CDEF with dots on digit3/digit1, no new load
    vecs[4] = '{-1, 24'h0, -1, 24'h0,
                mk(12'h762, 12'hB85, 12'hD60, 12'hE71)};

    reset_in = 1'b0; load  = 1'b0; value  = '0; dig_en  = '0; dp_en  = '0;
    rst6     = 1'b0; load6 = 1'b0; value6 = '0; dig_en6 = '0; dp_en6 = '0;
    repeat (3) @(negedge clk);
    reset_in = 1'b1;

    for (int n = 0; n < 5; n++) run_frame(n, vecs[n]);

    // F5: load at offset 3 makes pending, then reset mid digit1 SHOW
    for (int k = 0; k < 20; k++) begin
      check($sformatf("pend_f5_k%0d", k), {31'd0, upd_pending}, {31'd0, (k > 3)});
      load = (k == 3);
      if (k == 3) {value, dig_en, dp_en} = {16'hFFFF, 4'hF, 4'hF};
      @(negedge clk);
    end
    load     = 1'b0;
    reset_in = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("rst_seg_%0d", j), {20'd0, segment}, 32'hFFF);
      check($sformatf("rst_fd_%0d", j), {31'd0, frame_done}, 32'd0);
      check($sformatf("rst_pend_%0d", j), {31'd0, upd_pending}, 32'd0);
    end
    reset_in = 1'b1;

    // F6: shadow cleared by reset, everything dark
    run_frame(6, '{-1, 24'h0, -1, 24'h0, mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF)});
    @(negedge clk);
    check("main_queue_drained", exp_q.size(), 32'd0);
    reset_in = 1'b0;

    // No-blank instance: load 0123 on the first cycle after reset release
    @(negedge clk);
    rst6    = 1'b1;
    load6   = 1'b1;
    value6  = 16'h0123;
    dig_en6 = 4'hF;
    dp_en6  = 4'h0;
    exp6_q.push_back(mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF));
    exp6_q.push_back(mk(12'h703, 12'hB9F, 12'hD25, 12'hE0D));
    @(negedge clk);
    load6 = 1'b0;
    check("pend6_after_load", {31'd0, upd_pending6}, 32'd1);
    repeat (40) @(negedge clk);
    check("six_queue_drained", exp6_q.size(), 32'd0);
    rst6 = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
